// File: rtl/controlador_pulso.sv
// Period-counter pulse sequencer: runs N periods (or forever) and drives the low-active window f.
// Optional `CONTROLADOR_PULSO_CONTADOR_EN adds the PeriodosFeitos completed-period counter.
module controlador_pulso #(
    parameter int unsigned LARGURA          = 9,
    parameter int unsigned PERIODO_PADRAO   = 500,
    parameter int unsigned BAIXO_INI_PADRAO = 19,
    parameter int unsigned BAIXO_FIM_PADRAO = 90,
    parameter int unsigned LARGURA_CICLOS   = 8
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Inicio,
    input  logic                      Parar,
    input  logic [LARGURA_CICLOS-1:0] NumCiclos,
    input  logic                      CfgValido,
    output logic                      CfgPronto,
    input  logic [LARGURA-1:0]        CfgPeriodo,
    input  logic [LARGURA-1:0]        CfgBaixoIni,
    input  logic [LARGURA-1:0]        CfgBaixoFim,
    output logic                      f,
    output logic                      Ocupado,
    output logic                      Fim,
`ifdef CONTROLADOR_PULSO_CONTADOR_EN
    output logic [15:0]               PeriodosFeitos,
`endif
    output logic [LARGURA-1:0]        Contagem
);

    typedef enum logic [0:0] {StOcioso, StRodando} estado_t;

    estado_t                   estado_q;
    logic [LARGURA-1:0]        contagem_q;
    logic                      f_q;
    logic                      fim_q;
    logic [LARGURA_CICLOS-1:0] restantes_q;
    logic                      continuo_q;
    logic [LARGURA-1:0]        periodo_ativo_q, ini_ativo_q, fim_ativo_q;
    logic                      pend_valido_q;
    logic [LARGURA-1:0]        pend_periodo_q, pend_ini_q, pend_fim_q;
`ifdef CONTROLADOR_PULSO_CONTADOR_EN
    logic [15:0]               periodos_q;
`endif

    logic                      transfere;
    logic                      fronteira;
    logic                      na_janela;
    logic [LARGURA-1:0]        cfg_periodo_lim;

    assign CfgPronto       = (estado_q == StOcioso) ? 1'b1 : !pend_valido_q;
    assign transfere       = CfgValido && CfgPronto;
    assign fronteira       = (contagem_q == periodo_ativo_q - LARGURA'(1));
    assign na_janela       = (ini_ativo_q < contagem_q) && (contagem_q < fim_ativo_q);
    // Periods shorter than 2 would make the boundary ambiguous.
    assign cfg_periodo_lim = (CfgPeriodo < LARGURA'(2)) ? LARGURA'(2) : CfgPeriodo;

    assign f        = f_q;
    assign Fim      = fim_q;
    assign Ocupado  = (estado_q == StRodando);
    assign Contagem = contagem_q;
`ifdef CONTROLADOR_PULSO_CONTADOR_EN
    assign PeriodosFeitos = periodos_q;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado_q        <= StOcioso;
            contagem_q      <= '0;
            f_q             <= 1'b1;
            fim_q           <= 1'b0;
            restantes_q     <= '0;
            continuo_q      <= 1'b0;
            periodo_ativo_q <= LARGURA'(PERIODO_PADRAO);
            ini_ativo_q     <= LARGURA'(BAIXO_INI_PADRAO);
            fim_ativo_q     <= LARGURA'(BAIXO_FIM_PADRAO);
            pend_valido_q   <= 1'b0;
            pend_periodo_q  <= '0;
            pend_ini_q      <= '0;
            pend_fim_q      <= '0;
`ifdef CONTROLADOR_PULSO_CONTADOR_EN
            periodos_q      <= '0;
`endif
        end else begin
            fim_q <= 1'b0;
            unique case (estado_q)
                StOcioso: begin
                    contagem_q <= '0;
                    f_q        <= 1'b1;
                    if (transfere) begin
                        periodo_ativo_q <= cfg_periodo_lim;
                        ini_ativo_q     <= CfgBaixoIni;
                        fim_ativo_q     <= CfgBaixoFim;
                    end
                    if (Inicio && !Parar) begin
                        estado_q    <= StRodando;
                        restantes_q <= NumCiclos;
                        continuo_q  <= (NumCiclos == '0);
`ifdef CONTROLADOR_PULSO_CONTADOR_EN
                        periodos_q  <= '0;
`endif
                    end
                end
                StRodando: begin
                    if (Parar || (fronteira && !continuo_q && restantes_q == LARGURA_CICLOS'(1)))
                    begin
                        // Leaving the run: accepted config must land in the active set,
                        // since the pending slot is invisible while idle.
                        estado_q      <= StOcioso;
                        contagem_q    <= '0;
                        f_q           <= 1'b1;
                        fim_q         <= 1'b1;
                        pend_valido_q <= 1'b0;
                        if (transfere) begin
                            periodo_ativo_q <= cfg_periodo_lim;
                            ini_ativo_q     <= CfgBaixoIni;
                            fim_ativo_q     <= CfgBaixoFim;
                        end else if (pend_valido_q) begin
                            periodo_ativo_q <= pend_periodo_q;
                            ini_ativo_q     <= pend_ini_q;
                            fim_ativo_q     <= pend_fim_q;
                        end
`ifdef CONTROLADOR_PULSO_CONTADOR_EN
                        if (!Parar && periodos_q != 16'hFFFF) periodos_q <= periodos_q + 16'd1;
`endif
                    end else begin
                        f_q <= !na_janela;
                        if (fronteira) begin
                            contagem_q <= '0;
                            if (!continuo_q) restantes_q <= restantes_q - LARGURA_CICLOS'(1);
                            if (pend_valido_q) begin
                                periodo_ativo_q <= pend_periodo_q;
                                ini_ativo_q     <= pend_ini_q;
                                fim_ativo_q     <= pend_fim_q;
                                pend_valido_q   <= 1'b0;
                            end
`ifdef CONTROLADOR_PULSO_CONTADOR_EN
                            if (periodos_q != 16'hFFFF) periodos_q <= periodos_q + 16'd1;
`endif
                        end else begin
                            contagem_q <= contagem_q + LARGURA'(1);
                        end
                        if (transfere) begin
                            pend_valido_q  <= 1'b1;
                            pend_periodo_q <= cfg_periodo_lim;
                            pend_ini_q     <= CfgBaixoIni;
                            pend_fim_q     <= CfgBaixoFim;
                        end
                    end
                end
                default: estado_q <= StOcioso;
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_pulso.sv
// Directed self-checking bench for controlador_pulso (default configuration).
module tb_controlador_pulso;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Inicio = 1'b0;
    logic       Parar = 1'b0;
    logic [7:0] NumCiclos = '0;
    logic       CfgValido = 1'b0;
    logic       CfgPronto;
    logic [8:0] CfgPeriodo = '0;
    logic [8:0] CfgBaixoIni = '0;
    logic [8:0] CfgBaixoFim = '0;
    logic       f;
    logic       Ocupado;
    logic       Fim;
    logic [8:0] Contagem;
`ifdef CONTROLADOR_PULSO_CONTADOR_EN
    logic [15:0] PeriodosFeitos;
`endif

    int checks = 0;
    int failures = 0;

    controlador_pulso dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Inicio      (Inicio),
        .Parar       (Parar),
        .NumCiclos   (NumCiclos),
        .CfgValido   (CfgValido),
        .CfgPronto   (CfgPronto),
        .CfgPeriodo  (CfgPeriodo),
        .CfgBaixoIni (CfgBaixoIni),
        .CfgBaixoFim (CfgBaixoFim),
        .f           (f),
        .Ocupado     (Ocupado),
        .Fim         (Fim),
`ifdef CONTROLADOR_PULSO_CONTADOR_EN
        .PeriodosFeitos (PeriodosFeitos),
`endif
        .Contagem    (Contagem)
    );

    always #5 Clock = ~Clock;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int exp_cnt, prev, bad_f, bad_c, nlow, nfim, nrun;

        ticks(2);
        Reset = 1'b0;
        check_val("rst_cnt", Contagem, 0);
        check_val("rst_f", f, 1);
        check_val("rst_ocup", Ocupado, 0);
        check_val("rst_fim", Fim, 0);
        check_val("rst_pronto", CfgPronto, 1);

        // Continuous run with default config: 500-cycle period, f low for prior count 20..89.
        Inicio = 1'b1; NumCiclos = 8'd0;
        tick();
        Inicio = 1'b0;
        check_val("t1_ocup", Ocupado, 1);
        check_val("t1_cnt0", Contagem, 0);
        check_val("t1_f0", f, 1);
        exp_cnt = 0; bad_f = 0; bad_c = 0; nlow = 0; nfim = 0;
        for (int i = 0; i < 1000; i++) begin
            prev = exp_cnt;
            exp_cnt = (exp_cnt + 1) % 500;
            tick();
            if (Contagem != exp_cnt) bad_c++;
            if (f != ((prev > 19 && prev < 90) ? 1'b0 : 1'b1)) bad_f++;
            if (!f) nlow++;
            if (Fim) nfim++;
        end
        check_val("t1_cnt_seq", bad_c, 0);
        check_val("t1_f_seq", bad_f, 0);
        check_val("t1_low", nlow, 140);
        check_val("t1_nofim", nfim, 0);
        check_val("t1_ocup_end", Ocupado, 1);

        // Abort mid-period.
        ticks(50);
        check_val("ab_cnt50", Contagem, 50);
        Parar = 1'b1;
        tick();
        Parar = 1'b0;
        check_val("ab_ocup", Ocupado, 0);
        check_val("ab_fim", Fim, 1);
        check_val("ab_f", f, 1);
        check_val("ab_cnt", Contagem, 0);
        tick();
        check_val("ab_fim_1cyc", Fim, 0);
        Parar = 1'b1;
        tick();
        Parar = 1'b0;
        check_val("ab_idle_nofim", Fim, 0);

        // Finite run of 3 periods.
        Inicio = 1'b1; NumCiclos = 8'd3;
        tick();
        Inicio = 1'b0;
        nrun = 0; nfim = 0;
        for (int i = 0; i < 1600; i++) begin
            if (Ocupado) nrun++;
            if (Fim) nfim++;
            tick();
        end
        check_val("fin_cycles", nrun, 1500);
        check_val("fin_fims", nfim, 1);
        check_val("fin_cnt", Contagem, 0);
        check_val("fin_f", f, 1);
        check_val("fin_ocup", Ocupado, 0);

        // Config offered mid-run is deferred to the boundary; a second offer waits for the slot.
        Inicio = 1'b1; NumCiclos = 8'd0;
        tick();
        Inicio = 1'b0;
        ticks(200);
        check_val("cf_cnt200", Contagem, 200);
        check_val("cf_pronto0", CfgPronto, 1);
        CfgValido = 1'b1; CfgPeriodo = 9'd100; CfgBaixoIni = 9'd9; CfgBaixoFim = 9'd30;
        tick();
        CfgPeriodo = 9'd60; CfgBaixoIni = 9'd5; CfgBaixoFim = 9'd10;
        check_val("cf_pronto_full", CfgPronto, 0);
        ticks(298);
        check_val("cf_cnt499", Contagem, 499);
        check_val("cf_pronto_held", CfgPronto, 0);
        tick();
        check_val("cf_wrap", Contagem, 0);
        check_val("cf_pronto_free", CfgPronto, 1);
        tick();
        CfgValido = 1'b0;
        check_val("cf_pronto_2nd", CfgPronto, 0);
        nlow = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!f) nlow++;
        end
        check_val("cf_low100", nlow, 20);
        check_val("cf_cnt_p100", Contagem, 1);
        ticks(58);
        check_val("cf_cnt59", Contagem, 59);
        tick();
        check_val("cf_wrap60", Contagem, 0);

        // Abort coinciding with a boundary yields a single Fim.
        ticks(59);
        check_val("pb_cnt59", Contagem, 59);
        Parar = 1'b1;
        tick();
        Parar = 1'b0;
        nfim = Fim ? 1 : 0;
        check_val("pb_ocup", Ocupado, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (Fim) nfim++;
        end
        check_val("pb_fims", nfim, 1);

        // Period below 2 clamps to 2; equal bounds give an empty window.
        CfgValido = 1'b1; CfgPeriodo = 9'd0; CfgBaixoIni = 9'd40; CfgBaixoFim = 9'd40;
        tick();
        CfgValido = 1'b0;
        Inicio = 1'b1; NumCiclos = 8'd0;
        tick();
        Inicio = 1'b0;
        bad_c = 0; bad_f = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (Contagem != (i % 2)) bad_c++;
            if (f != 1'b1) bad_f++;
        end
        check_val("cl_cnt_seq", bad_c, 0);
        check_val("cl_f_high", bad_f, 0);
        Parar = 1'b1;
        tick();
        Parar = 1'b0;
        check_val("cl_stop", Ocupado, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/controlador_pulso.md
Name: controlador_pulso

Overview:
Sequencer for the 9-bit period-counter pulse generator. Runs the counter for a programmed number of periods (or continuously) and drives the low-active window output f. Accepts new period/window settings through a valid/ready handshake and applies them only at a period boundary, so no period is ever truncated or glitched. Sits between the control logic that issues start/stop/config and the pulse output consumer.

Parameters:
LARGURA, 9, width of period counter and config fields
PERIODO_PADRAO, 500, period length (cycles) after reset
BAIXO_INI_PADRAO, 19, window lower bound after reset (f low when count > this)
BAIXO_FIM_PADRAO, 90, window upper bound after reset (f low when count < this)
LARGURA_CICLOS, 8, width of period-count request

Ports:
Clock  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
Inicio  input  1  start request, sampled in OCIOSO only
Parar  input  1  abort request, any state
NumCiclos  input  LARGURA_CICLOS  periods to run, sampled with Inicio; 0 = continuous
CfgValido  input  1  config offer valid
CfgPronto  output  1  config slot free
CfgPeriodo  input  LARGURA  new period length
CfgBaixoIni  input  LARGURA  new window lower bound (exclusive)
CfgBaixoFim  input  LARGURA  new window upper bound (exclusive)
f  output  1  pulse output, registered
Ocupado  output  1  high in RODANDO
Fim  output  1  one-cycle pulse when a finite run completes or is aborted
Contagem  output  LARGURA  current counter value

Behaviour:
- Reset (synchronous, wins over all inputs): state OCIOSO, Contagem=0, f=1, Ocupado=0, Fim=0, active config = defaults, pending slot empty, CfgPronto=1.
- States: OCIOSO, RODANDO. Ocupado = (state==RODANDO).
- OCIOSO -> RODANDO on Inicio && !Parar; latches NumCiclos into remaining-periods counter; Contagem starts 0 in first RODANDO cycle.
- RODANDO: Contagem increments by 1 each cycle; at Contagem == periodo_ativo-1 it wraps to 0 next cycle (period boundary).
- At boundary: pending config (if any) becomes active, slot empties; if finite run, remaining decrements; on reaching 0 -> OCIOSO, Contagem=0, Fim=1 for one cycle.
- Parar in RODANDO: next cycle OCIOSO, Contagem=0, f=1, Fim=1 one cycle. Parar in OCIOSO: no effect, no Fim. Parar and boundary same cycle: abort wins, single Fim.
- Inicio while RODANDO ignored.
- f registered, 1-cycle latency: f(t+1) = 0 if state RODANDO and baixo_ini < Contagem(t) < baixo_fim, else 1. f=1 in OCIOSO.
- Config handshake: transfer when CfgValido && CfgPronto. In OCIOSO, transfer writes active config directly; CfgPronto=1. In RODANDO, transfer writes one-deep pending slot; CfgPronto = !pending. Transfer in the same cycle as a boundary goes to pending and applies at the next boundary.
- Clamping on accept: CfgPeriodo < 2 stored as 2. BaixoIni >= BaixoFim stored as-is -> window empty, f stays 1. Bounds >= period simply never match.
- Reset mid-run: aborts immediately, no Fim pulse, pending config discarded.

Optional Feature:
Macro CONTROLADOR_PULSO_CONTADOR_EN. Defined: adds output PeriodosFeitos (16 bits), incremented at every completed period boundary in RODANDO (saturating at 65535), cleared by Reset and on every OCIOSO->RODANDO transition; aborted partial periods not counted. Undefined: port and logic absent, behaviour otherwise identical.

Test Plan:
- Reset then Inicio, NumCiclos=0, defaults -> f=0 exactly when delayed Contagem in 20..89 (70 cycles low per 500), period 500 repeats, Ocupado=1, no Fim.
- Inicio with NumCiclos=3 -> exactly 1500 RODANDO cycles, then OCIOSO, Contagem=0, single Fim pulse, f=1.
- RODANDO, offer Periodo=100, Ini=9, Fim=30 at Contagem=200 -> CfgPronto drops, current 500 period finishes unchanged, next period 100 cycles with f low for Contagem 10..29, CfgPronto returns 1 at boundary.
- Second offer while pending full -> CfgValido held, no transfer until boundary; then accepted next period.
- Parar at Contagem=50 -> next cycle OCIOSO, f=1, Fim=1; Parar with simultaneous boundary -> one Fim only.
- CfgPeriodo=0 in OCIOSO -> runs with period 2 (Contagem 0,1,0,1); Ini=40, Fim=40 -> f constantly 1.
